// File: rtl/buart_fifo_param.sv
// Parametrised UART core: 2-FF synchronised receiver with glitch rejection and
// sticky error flags, RX/TX FIFOs, and a back-to-back capable transmitter.
module buart_fifo_param #(
  parameter int CLK_DIV   = 217,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int RX_AW     = 3,
  parameter int TX_AW     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic             tx,
  input  logic             wr,
  input  logic [7:0]       tx_data,
  output logic             tx_full,
  output logic             busy,
  input  logic             rd,
  output logic [7:0]       rx_data,
  output logic             valid,
  output logic [RX_AW:0]   rx_count,
  input  logic             err_clr,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int NB = 2 + DATA_BITS + ((PARITY != 0) ? 1 : 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_PRE  = CW'(CLK_DIV - 2);
  localparam logic [CW-1:0] DIV_HALF = CW'(CLK_DIV / 2);
  localparam logic [7:0]    DMASK    = 8'((1 << DATA_BITS) - 1);

  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
                         S_PAR  = 3'd3, S_STOP  = 3'd4, S_BRK  = 3'd5;
  localparam logic [1:0] T_IDLE = 2'd0, T_LOAD = 2'd1, T_SHIFT = 2'd2;

  // ---------------- RX synchroniser ----------------
  logic rx_m, rxs;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  // ---------------- RX framing FSM ----------------
  logic [2:0]    rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          par_bad, rx_tick, rx_ones, par_mis;
  logic          rx_push, set_fe, set_pe, set_ov;

  assign rx_tick = (rx_cnt == DIV_LAST);
  assign rx_ones = (^rx_sh) ^ rxs;
  assign par_mis = (PARITY == 1) ? ~rx_ones : rx_ones;
  assign rx_push = (rx_st == S_STOP) && rx_tick && rxs && !par_bad;
  assign set_fe  = (rx_st == S_STOP) && rx_tick && !rxs;
  assign set_pe  = (rx_st == S_PAR) && rx_tick && par_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      par_bad <= 1'b0;
    end else begin
      case (rx_st)
        S_IDLE: if (!rxs) begin
          rx_st  <= S_START;
          rx_cnt <= '0;
        end
        S_START: if (rx_cnt == DIV_HALF) begin
          rx_st   <= rxs ? S_IDLE : S_DATA;
          rx_cnt  <= '0;
          rx_bit  <= '0;
          par_bad <= 1'b0;
        end else rx_cnt <= rx_cnt + 1'b1;
        S_DATA: if (rx_tick) begin
          rx_cnt <= '0;
          if (rx_bit == 3'(DATA_BITS - 1)) rx_st <= (PARITY != 0) ? S_PAR : S_STOP;
          else rx_bit <= rx_bit + 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        S_PAR: if (rx_tick) begin
          rx_cnt  <= '0;
          par_bad <= par_mis;
          rx_st   <= S_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        S_STOP: if (rx_tick) begin
          rx_cnt <= '0;
          rx_st  <= rxs ? S_IDLE : S_BRK;
        end else rx_cnt <= rx_cnt + 1'b1;
        S_BRK: if (rxs) rx_st <= S_IDLE;
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // Cleared while idle so unused upper bits push as zero.
  always_ff @(posedge clk) begin
    if (rx_st == S_IDLE) rx_sh <= '0;
    else if (rx_st == S_DATA && rx_tick) rx_sh[rx_bit] <= rxs;
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]   rx_mem [2**RX_AW];
  logic [RX_AW:0] rx_wp, rx_rp;
  logic         rx_full, rx_pop, rx_wr;

  assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                    (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
  assign valid    = (rx_wp != rx_rp);
  assign rx_pop   = rd && valid;
  assign rx_wr    = rx_push && (!rx_full || rx_pop);
  assign set_ov   = rx_push && rx_full && !rx_pop;
  assign rx_data  = rx_mem[rx_rp[RX_AW-1:0]];
  assign rx_count = rx_wp - rx_rp;

  always_ff @(posedge clk) if (rx_wr) rx_mem[rx_wp[RX_AW-1:0]] <= rx_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
    end
  end

  // ---------------- sticky error flags ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_fe | (frame_err  & ~err_clr);
      parity_err <= set_pe | (parity_err & ~err_clr);
      overrun    <= set_ov | (overrun    & ~err_clr);
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]     tx_mem [2**TX_AW];
  logic [TX_AW:0] tx_wp, tx_rp;
  logic           tx_empty, tx_pop, tx_wr;
  logic [7:0]     tx_head;

  assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                    (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_wr    = wr && (!tx_full || tx_pop);
  assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];

  always_ff @(posedge clk) if (tx_wr) tx_mem[tx_wp[TX_AW-1:0]] <= tx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_wr)  tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
    end
  end

  // ---------------- TX settle timer and serialiser ----------------
  logic [CW-1:0] settle_cnt, tx_cnt;
  logic [4:0]    settle_bits;
  logic          settled;
  logic [1:0]    ts;
  logic [3:0]    tx_left;
  logic [10:0]   tx_frame, tx_sh;
  logic          tx_q, tx_bit_end;

  assign settled    = settle_bits[4];
  assign tx_bit_end = (ts == T_SHIFT) && (tx_cnt == DIV_LAST);
  // Reloading one cycle before the stop bit ends makes frames back-to-back.
  assign tx_pop = !tx_empty && (((ts == T_IDLE) && settled) ||
                  ((ts == T_SHIFT) && (tx_left == 4'd0) && (tx_cnt == DIV_PRE)));
  assign busy   = !settled || (ts != T_IDLE) || !tx_empty;
  assign tx     = tx_q;

  always_comb begin
    tx_frame    = '1;
    tx_frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) if (i < DATA_BITS) tx_frame[1+i] = tx_head[i];
    if (PARITY != 0)
      tx_frame[1+DATA_BITS] = (PARITY == 1) ? ~^(tx_head & DMASK) : ^(tx_head & DMASK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt  <= '0;
      settle_bits <= '0;
    end else if (!settled) begin
      if (settle_cnt == DIV_LAST) begin
        settle_cnt  <= '0;
        settle_bits <= settle_bits + 1'b1;
      end else settle_cnt <= settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts      <= T_IDLE;
      tx_q    <= 1'b1;
      tx_cnt  <= '0;
      tx_left <= '0;
    end else begin
      case (ts)
        T_IDLE: if (tx_pop) ts <= T_LOAD;
        T_LOAD: begin
          tx_q    <= tx_sh[0];
          tx_left <= 4'(NB - 1);
          tx_cnt  <= '0;
          ts      <= T_SHIFT;
        end
        T_SHIFT: if (tx_pop) ts <= T_LOAD;
        else if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_left == 4'd0) ts <= T_IDLE;
          else begin
            tx_q    <= tx_sh[0];
            tx_left <= tx_left - 1'b1;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        default: ts <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop) tx_sh <= tx_frame;
    else if (ts == T_LOAD || (tx_bit_end && tx_left != 4'd0)) tx_sh <= {1'b1, tx_sh[10:1]};
  end

endmodule

// File: tb/tb_buart_fifo_param.sv
// Directed bench for buart_fifo_param: an 8N1 instance and a 7E1 instance, CLK_DIV=4.
module tb_buart_fifo_param;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic       rx = 1'b1, wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx, tx_full, busy, valid, frame_err, parity_err, overrun;
  logic [7:0] rx_data;
  logic [3:0] rx_count;

  logic       p_rx = 1'b1, p_rd = 1'b0, p_err_clr = 1'b0;
  logic       p_tx, p_tx_full, p_busy, p_valid, p_frame_err, p_parity_err, p_overrun;
  logic [7:0] p_rx_data;
  logic [3:0] p_rx_count;

  buart_fifo_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .RX_AW(3), .TX_AW(2)) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .wr(wr), .tx_data(tx_data),
    .tx_full(tx_full), .busy(busy), .rd(rd), .rx_data(rx_data), .valid(valid),
    .rx_count(rx_count), .err_clr(err_clr), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun));

  buart_fifo_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .RX_AW(3), .TX_AW(2)) dut_par (
    .clk(clk), .reset(reset), .rx(p_rx), .tx(p_tx), .wr(1'b0), .tx_data(8'h00),
    .tx_full(p_tx_full), .busy(p_busy), .rd(p_rd), .rx_data(p_rx_data), .valid(p_valid),
    .rx_count(p_rx_count), .err_clr(p_err_clr), .frame_err(p_frame_err),
    .parity_err(p_parity_err), .overrun(p_overrun));

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nb bits LSB first, 4 cycles each, then 2 idle cycles.
  task automatic send(input logic [10:0] fr, input int nb, input bit par);
    for (int b = 0; b < nb; b++) begin
      if (par) p_rx = fr[b];
      else     rx   = fr[b];
      tick(4);
    end
    tick(2);
  endtask

  function automatic logic [10:0] f8n1(input logic [7:0] d);
    return {2'b01, d, 1'b0};
  endfunction

  task automatic wait_valid(input bit par, input string tag);
    for (int i = 0; i < 60 && !(par ? p_valid : valid); i++) tick(1);
    check(tag, par ? p_valid : valid, 1'b1);
  endtask

  task automatic wait_tx_low(input int limit, output int n);
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      tick(1);
      n++;
    end
    check("tx_start_seen", tx, 1'b0);
  endtask

  // Samples tx every cycle for one 40-cycle frame, starting on the first start-bit cycle.
  task automatic grab_frame(input logic [7:0] d, input string tag);
    logic [39:0] got, exp;
    logic [9:0]  bits;
    bits = {1'b1, d, 1'b0};
    for (int c = 0; c < 40; c++) exp[c] = bits[c/4];
    for (int c = 0; c < 40; c++) begin
      got[c] = tx;
      tick(1);
    end
    check(tag, got, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---------------- reset state ----------------
    tick(2);
    check("reset_state", {tx, valid, rx_count, tx_full, busy, frame_err, parity_err, overrun},
          {1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 3'b000});
    reset = 1'b0;
    tick(80);
    check("settle_done_busy", busy, 1'b0);

    // ---------------- single 8N1 receive ----------------
    send(f8n1(8'hA5), 10, 1'b0);
    wait_valid(1'b0, "a5_valid");
    check("a5_data", rx_data, 8'hA5);
    check("a5_count", rx_count, 4'd1);
    rd = 1'b1; tick(1); rd = 1'b0;
    check("a5_popped", {valid, rx_count}, {1'b0, 4'd0});

    // ---------------- three back-to-back TX frames ----------------
    tx_data = 8'h3C; wr = 1'b1; tick(1);
    check("txf_after_w1", tx_full, 1'b0);
    tx_data = 8'h81; tick(1);
    check("txf_after_w2", tx_full, 1'b0);
    tx_data = 8'hFF; tick(1);
    check("txf_after_w3", tx_full, 1'b0);
    wr = 1'b0;
    wait_tx_low(50, n);
    check("tx_busy_during", busy, 1'b1);
    grab_frame(8'h3C, "tx_frame_3c");
    grab_frame(8'h81, "tx_frame_81");
    grab_frame(8'hFF, "tx_frame_ff");
    check("tx_idle_after", {busy, tx}, {1'b0, 1'b1});

    // ---------------- RX overrun ----------------
    for (int i = 0; i < 9; i++) send(f8n1(8'(i)), 10, 1'b0);
    check("ovr_count", rx_count, 4'd8);
    check("ovr_flag", overrun, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovr_pop%0d", i), rx_data, 8'(i));
      rd = 1'b1; tick(1); rd = 1'b0;
    end
    check("ovr_empty", valid, 1'b0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);

    // ---------------- 7E1 parity ----------------
    send({1'b1, 1'b1, 7'h55, 1'b0}, 10, 1'b1);
    check("par_bad_flag", {p_parity_err, p_valid, p_frame_err}, {1'b1, 1'b0, 1'b0});
    send({1'b1, 1'b1, 7'h2A, 1'b0}, 10, 1'b1);
    wait_valid(1'b1, "par_good_valid");
    check("par_good_data", p_rx_data, 8'h2A);
    check("par_sticky", p_parity_err, 1'b1);
    p_err_clr = 1'b1; tick(1); p_err_clr = 1'b0;
    check("par_cleared", p_parity_err, 1'b0);

    // ---------------- glitch and held-low line ----------------
    rx = 1'b0; tick(1); rx = 1'b1; tick(20);
    check("glitch_quiet", {valid, frame_err, parity_err, overrun}, 4'b0000);
    rx = 1'b0; tick(60);
    check("break_frame_err", {frame_err, valid}, {1'b1, 1'b0});
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    tick(59); rx = 1'b1; tick(8);
    check("break_single", {frame_err, valid, rx_count}, {1'b0, 1'b0, 4'd0});
    send(f8n1(8'h11), 10, 1'b0);
    wait_valid(1'b0, "after_break_valid");
    check("after_break_data", rx_data, 8'h11);
    rd = 1'b1; tick(1); rd = 1'b0;

    // ---------------- reset mid-frame ----------------
    tx_data = 8'h5A; wr = 1'b1; tick(1); wr = 1'b0;
    rx = 1'b0;
    wait_tx_low(50, n);
    tx_data = 8'h77; wr = 1'b1; tick(1); wr = 1'b0;
    tick(8);
    #2 reset = 1'b1;
    #1 check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_state", {valid, rx_count, tx_full, busy}, {1'b0, 4'd0, 1'b0, 1'b1});
    @(negedge clk);
    reset = 1'b0; rx = 1'b1;
    tx_data = 8'hC3; wr = 1'b1; tick(1); wr = 1'b0;
    n = 1;
    while (tx !== 1'b0 && n < 200) begin
      check($sformatf("settle_busy%0d", n), busy, 1'b1);
      tick(1);
      n++;
    end
    check("settle_len_ok", (n >= 64 && n <= 70), 1'b1);
    grab_frame(8'hC3, "post_reset_frame");
    check("post_reset_idle", {busy, valid}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
